// File: rtl/serial_compare_pkg.sv
// Shared types and sizing helpers for the bit-serial magnitude comparator.
package serial_compare_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

    // Bits needed to index an operand of w bits (MSB index is w-1).
    function automatic int idx_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    // Bits needed to hold a bit count from 0 up to and including w.
    function automatic int count_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_compare_bit_compare.sv
// Single-bit magnitude compare cell. Once either skip input is set the
// decision is sticky, so lower bits can no longer change the outcome.
module bit_compare (
    input  logic a,
    input  logic b,
    input  logic a_skip,
    input  logic b_skip,
    output logic a_g,
    output logic b_g
);

    // Combinational cell: propagate an earlier decision or decide on this bit.
    always_comb begin
        a_g = a_skip | (~b_skip & a & ~b);
        b_g = b_skip | (~a_skip & ~a & b);
    end

endmodule

// File: rtl/serial_compare_ctrl.sv
// Bit-serial magnitude comparator controller: captures two operands, walks a
// single bit_compare cell from MSB to LSB and returns the result over a
// valid/ready handshake.
module serial_compare_ctrl
    import serial_compare_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     start_ready,
    input  logic [WIDTH-1:0]         op_a,
    input  logic [WIDTH-1:0]         op_b,
    input  logic                     abort,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     a_gt,
    output logic                     b_gt,
    output logic                     eq,
    output logic [$clog2(WIDTH):0]   bits_used
);

    localparam int IW = idx_width(WIDTH);
    localparam int CW = count_width(WIDTH);
    localparam logic [IW-1:0] IDX_TOP   = IW'(WIDTH - 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(WIDTH);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              a_skip_q, a_skip_d;
    logic              b_skip_q, b_skip_d;
    logic [CW-1:0]     count_q, count_d;

    logic              a_bit, b_bit;
    logic              a_g, b_g;

    assign a_bit = a_q[idx_q];
    assign b_bit = b_q[idx_q];

    bit_compare u_cell (
        .a      (a_bit),
        .b      (b_bit),
        .a_skip (a_skip_q),
        .b_skip (b_skip_q),
        .a_g    (a_g),
        .b_g    (b_g)
    );

    // Next-state logic: capture in IDLE, one bit per clock in RUN, hold in DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        a_skip_d = a_skip_q;
        b_skip_d = b_skip_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    idx_d    = IDX_TOP;
                    a_skip_d = 1'b0;
                    b_skip_d = 1'b0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    a_skip_d = a_g;
                    b_skip_d = b_g;
                    count_d  = (count_q == COUNT_MAX) ? count_q : count_q + CW'(1);
                    // idx stops at zero rather than wrapping; zero is the last bit.
                    if ((idx_q == '0) || (EARLY_EXIT && (a_g | b_g))) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end
            end
            DONE: begin
                // Abort wins over the handshake; both lead back to IDLE.
                if (abort || res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            a_skip_q <= 1'b0;
            b_skip_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            a_skip_q <= a_skip_d;
            b_skip_q <= b_skip_d;
            count_q  <= count_d;
        end
    end

    // Outputs are gated by state so nothing stale leaks outside DONE.
    always_comb begin
        start_ready = (state_q == IDLE);
        busy        = (state_q == RUN);
        res_valid   = (state_q == DONE);
        a_gt        = res_valid & a_skip_q;
        b_gt        = res_valid & b_skip_q;
        eq          = res_valid & ~(a_skip_q | b_skip_q);
        bits_used   = res_valid ? count_q : '0;
    end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl: one instance with early exit, one
// examining every bit, driven in lockstep from the same inputs.
module tb_serial_compare_ctrl;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic [WIDTH-1:0] op_a, op_b;
    logic abort;
    logic res_ready;

    logic sr1, busy1, v1, agt1, bgt1, eq1;
    logic sr0, busy0, v0, agt0, bgt0, eq0;
    logic [$clog2(WIDTH):0] bu1, bu0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_compare_ctrl #(.WIDTH(WIDTH), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk(clk), .rst_n(rst_n), .start(start), .start_ready(sr1),
        .op_a(op_a), .op_b(op_b), .abort(abort), .busy(busy1),
        .res_valid(v1), .res_ready(res_ready), .a_gt(agt1), .b_gt(bgt1),
        .eq(eq1), .bits_used(bu1)
    );

    serial_compare_ctrl #(.WIDTH(WIDTH), .EARLY_EXIT(1'b0)) u_dut_full (
        .clk(clk), .rst_n(rst_n), .start(start), .start_ready(sr0),
        .op_a(op_a), .op_b(op_b), .abort(abort), .busy(busy0),
        .res_valid(v0), .res_ready(res_ready), .a_gt(agt0), .b_gt(bgt0),
        .eq(eq0), .bits_used(bu0)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       agt;
        logic       bgt;
        logic       eqv;
        int         lat_ee;
        int         lat_full;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start a compare and record, per instance, the clock at which res_valid rose.
    task automatic run_cmp(input logic [7:0] a, input logic [7:0] b,
                           input bit disturb, output int l1, output int l0);
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1; res_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        l1 = 0; l0 = 0;
        for (int c = 1; c <= WIDTH + 4 && (l1 == 0 || l0 == 0); c++) begin
            if (disturb) begin
                @(negedge clk);
                op_a = 8'h00; op_b = 8'hFF; start = ~start;
            end
            @(posedge clk); #1;
            if (l1 == 0 && v1) l1 = c;
            if (l0 == 0 && v0) l0 = c;
        end
        start = 1'b0;
    endtask

    // Complete the handshake on both instances and confirm they went idle.
    task automatic ack(input string name);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({name, "_idle_ee"}, int'(sr1 & ~v1), 1);
        chk({name, "_idle_full"}, int'(sr0 & ~v0), 1);
    endtask

    task automatic no_stale(input string name);
        bit seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (v1 || v0) seen = 1'b1;
        end
        chk(name, int'(seen), 0);
    endtask

    initial begin
        int l1, l0;
        vecs[0] = '{8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 8, 8};
        vecs[1] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1, 8};
        vecs[2] = '{8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 8, 8};
        vecs[3] = '{8'hF0, 8'hE0, 1'b1, 1'b0, 1'b0, 4, 8};
        vecs[4] = '{8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 7, 8};
        vecs[5] = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1, 8};
        vecs[6] = '{8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0, 8, 8};
        vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8, 8};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
        op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ready", int'(sr1), 1);
        chk("rst_busy", int'(busy1 | busy0), 0);
        chk("rst_valid", int'(v1 | v0), 0);
        chk("rst_flags", int'({agt1, bgt1, eq1, agt0, bgt0, eq0}), 0);
        chk("rst_bits_used", int'(bu1) + int'(bu0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of directed compares.
        for (int i = 0; i < 8; i++) begin
            run_cmp(vecs[i].a, vecs[i].b, 1'b0, l1, l0);
            chk($sformatf("v%0d_lat_ee", i), l1, vecs[i].lat_ee);
            chk($sformatf("v%0d_lat_full", i), l0, vecs[i].lat_full);
            chk($sformatf("v%0d_agt_ee", i), int'(agt1), int'(vecs[i].agt));
            chk($sformatf("v%0d_bgt_ee", i), int'(bgt1), int'(vecs[i].bgt));
            chk($sformatf("v%0d_eq_ee", i), int'(eq1), int'(vecs[i].eqv));
            chk($sformatf("v%0d_bu_ee", i), int'(bu1), vecs[i].lat_ee);
            chk($sformatf("v%0d_agt_full", i), int'(agt0), int'(vecs[i].agt));
            chk($sformatf("v%0d_bgt_full", i), int'(bgt0), int'(vecs[i].bgt));
            chk($sformatf("v%0d_eq_full", i), int'(eq0), int'(vecs[i].eqv));
            chk($sformatf("v%0d_bu_full", i), int'(bu0), vecs[i].lat_full);
            ack($sformatf("v%0d", i));
        end

        // Back-pressure: result holds, start pulses are ignored.
        run_cmp(8'h12, 8'h13, 1'b0, l1, l0);
        chk("bp_lat", l1, 8);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = 1'b1; op_a = 8'hC3 + 8'(k); op_b = 8'h11;
            @(posedge clk); #1;
            chk($sformatf("bp%0d_valid", k), int'(v1 & v0), 1);
            chk($sformatf("bp%0d_bgt", k), int'(bgt1 & bgt0 & ~agt1 & ~eq1), 1);
            chk($sformatf("bp%0d_start_ready", k), int'(sr1 | sr0), 0);
            chk($sformatf("bp%0d_bu", k), int'(bu1), 8);
        end
        // Start coinciding with the handshake is ignored, accepted one clock later.
        @(negedge clk);
        res_ready = 1'b1; start = 1'b1; op_a = 8'h01; op_b = 8'h02;
        @(posedge clk); #1;
        chk("hs_start_ignored", int'(sr1 & sr0 & ~busy1 & ~busy0), 1);
        @(posedge clk); #1;
        start = 1'b0; res_ready = 1'b0;
        chk("hs_start_next", int'(busy1 & busy0), 1);
        l1 = 0;
        for (int c = 1; c <= 12 && !(v1 && v0); c++) begin
            @(posedge clk); #1;
            if (l1 == 0 && v1) l1 = c;
        end
        chk("hs_lat_ee", l1, 7);
        chk("hs_bgt", int'(bgt1 & bgt0), 1);
        chk("hs_bu_ee", int'(bu1), 7);
        ack("hs");

        // Operand inputs and start toggling during RUN do not disturb the result.
        run_cmp(8'hF0, 8'hE0, 1'b1, l1, l0);
        chk("dist_lat_ee", l1, 4);
        chk("dist_agt", int'(agt1 & agt0 & ~bgt1 & ~bgt0), 1);
        chk("dist_bu_ee", int'(bu1), 4);
        chk("dist_bu_full", int'(bu0), 8);
        ack("dist");

        // Abort on the third RUN cycle.
        @(negedge clk);
        start = 1'b1; op_a = 8'h5A; op_b = 8'h5A;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_run_idle", int'(sr1 & sr0 & ~busy1 & ~busy0 & ~v1 & ~v0), 1);
        no_stale("abort_run_no_valid");
        run_cmp(8'h01, 8'h02, 1'b0, l1, l0);
        chk("after_abort_bgt", int'(bgt1 & bgt0), 1);
        chk("after_abort_lat", l1, 7);
        ack("after_abort");

        // Abort in DONE wins over a simultaneous handshake.
        run_cmp(8'h80, 8'h7F, 1'b0, l1, l0);
        @(negedge clk);
        abort = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; res_ready = 1'b0;
        chk("abort_done_idle", int'(sr1 & sr0 & ~v1 & ~v0), 1);
        chk("abort_done_flags", int'({agt1, agt0, eq1, eq0}), 0);

        // Abort in IDLE is harmless.
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle", int'(sr1 & sr0 & ~busy1), 1);

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        start = 1'b1; op_a = 8'h5A; op_b = 8'h5A;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy1 | busy0), 0);
        chk("arst_start_ready", int'(sr1 & sr0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        no_stale("arst_no_stale");
        run_cmp(8'hFF, 8'h00, 1'b0, l1, l0);
        chk("arst_after_agt", int'(agt1 & agt0), 1);
        chk("arst_after_lat", l1, 1);
        ack("arst_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_compare_ctrl.md
Name: serial_compare_ctrl

Overview:
- Bit-serial magnitude comparator controller for the 8-bit ALU comparator path.
- Captures two unsigned WIDTH-bit operands and sequences a single bit_compare cell from MSB to LSB, one bit per clock.
- Keeps the skip flags in registers between bits, optionally stops early, and returns a greater/less/equal result over a valid/ready handshake.
- Trades latency for area against the fully unrolled comparator chain.

Parameters:
- WIDTH, 8, operand width in bits; legal range is 2 or more.
- EARLY_EXIT, 1, when 1 the sequence terminates on the first cycle either skip flag becomes set; when 0 all WIDTH bits are always examined.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a compare; accepted only when start_ready=1.
- start_ready  output  1  high only in IDLE.
- op_a  input  WIDTH  operand A; sampled on the accepting edge.
- op_b  input  WIDTH  operand B; sampled on the accepting edge.
- abort  input  1  synchronous cancel; returns to IDLE.
- busy  output  1  high in RUN.
- res_valid  output  1  high in DONE; result outputs are stable while high.
- res_ready  input  1  consumer accepts the result.
- a_gt  output  1  op_a > op_b.
- b_gt  output  1  op_b > op_a.
- eq  output  1  op_a == op_b; equals ~a_gt & ~b_gt in DONE.
- bits_used  output  $clog2(WIDTH)+1  number of bits examined for the held result.

Behaviour:
- Reset is asynchronous and active-low on rst_n, clocked by clk. While rst_n=0:
  - state=IDLE.
  - All registers clear: operand regs, idx, a_skip_q, b_skip_q, count.
  - Outputs: start_ready=1, busy=0, res_valid=0, a_gt=0, b_gt=0, eq=0, bits_used=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures op_a/op_b, sets idx=WIDTH-1, clears both skip regs and count, then moves to RUN.
  - start=0 holds IDLE.
- RUN: the bit_compare cell is driven with a_q[idx], b_q[idx], a_skip_q, b_skip_q. At each edge:
  - a_skip_q <= a_g and b_skip_q <= b_g.
  - count <= count+1.
  - If idx==0, or (EARLY_EXIT and (a_g|b_g)), move to DONE. Otherwise idx <= idx-1.
- Cell function (fixed): a_g = a_skip | (~b_skip & a & ~b); b_g = b_skip | (~a_skip & ~a & b).
- DONE:
  - a_gt=a_skip_q, b_gt=b_skip_q, eq=~(a_skip_q|b_skip_q), bits_used=count; all held stable.
  - res_valid & res_ready moves to IDLE on that edge.
  - Without res_ready the result holds indefinitely (back-pressure).
- Latency: res_valid rises N clocks after the start-accept edge.
  - N = WIDTH if EARLY_EXIT=0, or if no difference is found.
  - Otherwise N = WIDTH - i, where i is the index of the highest differing bit.
- start while not IDLE is ignored; it is neither queued nor able to corrupt operands.
- start in the same cycle as the DONE->IDLE handshake is ignored (start_ready=0 in DONE); the new start is accepted in the following cycle.
- abort=1 in RUN or DONE forces IDLE on the next edge, clears outputs, and produces no res_valid. abort in IDLE has no effect. abort has priority over the handshake and start.
- Operand inputs changing during RUN do not affect the result.
- rst_n asserted mid-RUN or mid-DONE clears everything immediately; after release the block is in IDLE and never emits a stale result.
- Counters:
  - idx is $clog2(WIDTH) bits wide and never underflows; the exit is checked at idx==0.
  - count saturates at WIDTH.

Decomposition:
- Shared package serial_compare_pkg holds:
  - The state enum typedef {IDLE, RUN, DONE}, 2-bit encoding.
  - Localparams for the default WIDTH and the idx/count width functions.
- One sub-module: the existing bit_compare cell, instantiated once.
- The FSM, operand registers and counter live in serial_compare_ctrl.

Test Plan:
- Reset, then start with op_a=0x5A, op_b=0x5A, res_ready=1 -> res_valid after 8 clocks; eq=1, a_gt=0, b_gt=0, bits_used=8.
- EARLY_EXIT=1, op_a=0x80, op_b=0x7F -> res_valid 1 clock after accept; a_gt=1, bits_used=1. With EARLY_EXIT=0 the same result arrives after 8 clocks with bits_used=8.
- op_a=0x12, op_b=0x13 -> b_gt=1 after 8 clocks. Hold res_ready=0 for 5 clocks -> result and res_valid stable, start pulses ignored, start_ready=0.
- op_a=0xF0, op_b=0xE0 started; during RUN change op_a to 0x00 and pulse start -> result still a_gt=1 with bits_used=4.
- abort at the 3rd RUN cycle -> IDLE next edge, res_valid never asserts, start_ready=1. A new compare of 0x01 vs 0x02 then gives b_gt=1.
- rst_n pulled low mid-RUN asynchronously (between edges) -> outputs clear immediately. After release, no res_valid appears until a new start.
